poly_carry_resolve: RTL and testbench

Sequential carry resolver sitting downstream of the polynomial squarer. It accepts one redundant product vector: CpaCoeffs segments, each CpaBits+1 wide, with the top bit being a carry into the next segment. It ripples the inter-segment carries one segment per cycle and streams the canonical NumBits2x-bit binary result, least-significant word first, over a valid/ready interface. It is the consumer of the squarer's carry-propagated product form and feeds modular reduction and readback.

---
 rtl/mrt_pkg.sv | 21 ++
 rtl/carry_seg_add.sv | 24 ++
 rtl/poly_carry_resolve.sv | 126 ++++++++++++
 tb/tb_poly_carry_resolve.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mrt_pkg.sv
// Purpose: shared parameters, segment type and resolver state enum for the multiplier result path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mrt_pkg;

   localparam int unsigned NumCoeffs      = 2;
   localparam int unsigned WordBits       = 16;
   localparam int unsigned NumBits2x      = 2 * NumCoeffs * WordBits;

   // Default carry-propagate segment payload width
   localparam int unsigned CpaBitsDefault = 16;

   // One redundant segment: payload plus a carry bit into the next segment
   typedef logic [CpaBitsDefault:0] cpa_seg_t;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } resolve_state_e;

endpackage

// File: rtl/carry_seg_add.sv
// Purpose: W-bit payload plus two single-bit carries, giving a W-bit word and one carry out.
// Latency: combinational.
// Backpressure: none (pure datapath).
module carry_seg_add #(
   parameter int unsigned W = 16
) (
   input  logic [W-1:0] i_a,
   input  logic         i_b,
   input  logic         i_c,
   output logic [W-1:0] o_sum,
   output logic         o_cout
);

   logic [W:0] w_sum;

   // Max value is 2^W + 1, so a W+1-bit result never loses a carry
   always_comb begin
      w_sum = {1'b0, i_a} + {{W{1'b0}}, i_b} + {{W{1'b0}}, i_c};
   end

   assign o_sum  = w_sum[W-1:0];
   assign o_cout = w_sum[W];

endmodule

// File: rtl/poly_carry_resolve.sv
// Purpose: ripple inter-segment carries of a redundant product and stream canonical words, LSW first.
// Latency: word 0 one cycle after acceptance, one word per cycle; optional is_zero_o via MRT_CARRY_RESOLVE_ZDETECT_EN.
// Backpressure: out_ready_i low holds all state and outputs; input accepted only when idle or on the last beat handshake.
module poly_carry_resolve
   import mrt_pkg::*;
#(
   parameter  int unsigned CpaBits   = CpaBitsDefault,
   parameter  int unsigned CpaCoeffs = 2 * NumCoeffs * WordBits / CpaBits,
   localparam int unsigned IdxW      = (CpaCoeffs > 1) ? $clog2(CpaCoeffs) : 1
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic                              in_valid_i,
   output logic                              in_ready_o,
   input  logic [CpaCoeffs-1:0][CpaBits:0]   cpa_product_i,
   output logic                              out_valid_o,
   input  logic                              out_ready_i,
   output logic [CpaBits-1:0]                word_o,
   output logic [IdxW-1:0]                   idx_o,
   output logic                              last_o,
`ifdef MRT_CARRY_RESOLVE_ZDETECT_EN
   output logic                              is_zero_o,
`endif
   output logic                              overflow_o
);

   localparam logic [IdxW-1:0] LastIdx = IdxW'(CpaCoeffs - 1);

   resolve_state_e                  r_state;
   resolve_state_e                  w_state_nxt;
   logic [CpaCoeffs-1:0][CpaBits:0] r_seg;
   logic [IdxW-1:0]                 r_idx;
   logic                            r_carry;

   logic                            w_run;
   logic                            w_last;
   logic                            w_accept;
   logic                            w_beat;
   logic [IdxW-1:0]                 w_prev_idx;
   logic                            w_hi_prev;
   logic [CpaBits-1:0]              w_sum;
   logic                            w_cout;

   assign w_run      = (r_state == RUN);
   assign w_last     = w_run && (r_idx == LastIdx);
   assign w_beat     = w_run && out_ready_i;
   assign in_ready_o = (r_state == IDLE) || (w_last && out_ready_i);
   assign w_accept   = in_valid_i && in_ready_o;

   // Segment 0 has no lower neighbour, so its incoming high bit is zero
   assign w_prev_idx = r_idx - IdxW'(1);
   assign w_hi_prev  = (r_idx == '0) ? 1'b0 : r_seg[w_prev_idx][CpaBits];

   carry_seg_add #(
      .W (CpaBits)
   ) u_add (
      .i_a    (r_seg[r_idx][CpaBits-1:0]),
      .i_b    (w_hi_prev),
      .i_c    (r_carry),
      .o_sum  (w_sum),
      .o_cout (w_cout)
   );

   // State register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state: a load on the final beat keeps RUN so results stream without a bubble
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept) w_state_nxt = RUN;
         end
         RUN: begin
            if (w_beat && w_last) w_state_nxt = w_accept ? RUN : IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Vector capture on acceptance; carry and index advance on each beat handshake
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_seg   <= '0;
         r_idx   <= '0;
         r_carry <= 1'b0;
      end else if (w_accept) begin
         r_seg   <= cpa_product_i;
         r_idx   <= '0;
         r_carry <= 1'b0;
      end else if (w_beat) begin
         r_carry <= w_cout;
         r_idx   <= w_last ? '0 : r_idx + IdxW'(1);
      end
   end

   assign out_valid_o = w_run;
   assign word_o      = w_run ? w_sum : '0;
   assign idx_o       = r_idx;
   assign last_o      = w_last;
   assign overflow_o  = w_last && (w_cout || r_seg[CpaCoeffs-1][CpaBits]);

`ifdef MRT_CARRY_RESOLVE_ZDETECT_EN
   logic r_nonzero;

   // Sticky flag: set once any emitted word of the current result is nonzero
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_nonzero <= 1'b0;
      end else if (w_accept) begin
         r_nonzero <= 1'b0;
      end else if (w_beat && (w_sum != '0)) begin
         r_nonzero <= 1'b1;
      end
   end

   assign is_zero_o = w_last && !r_nonzero && (w_sum == '0) && !overflow_o;
`endif

endmodule

// File: tb/tb_poly_carry_resolve.sv
module tb_poly_carry_resolve;

   localparam int unsigned CpaBits   = 16;
   localparam int unsigned CpaCoeffs = 4;

   logic                            clk_i;
   logic                            rst_ni;
   logic                            in_valid_i;
   logic                            in_ready_o;
   logic [CpaCoeffs-1:0][CpaBits:0] cpa_product_i;
   logic                            out_valid_o;
   logic                            out_ready_i;
   logic [CpaBits-1:0]              word_o;
   logic [1:0]                      idx_o;
   logic                            last_o;
   logic                            overflow_o;
`ifdef MRT_CARRY_RESOLVE_ZDETECT_EN
   logic                            is_zero_o;
`endif

   int n_cmp = 0;
   int n_err = 0;

   poly_carry_resolve #(
      .CpaBits   (CpaBits),
      .CpaCoeffs (CpaCoeffs)
   ) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .in_valid_i    (in_valid_i),
      .in_ready_o    (in_ready_o),
      .cpa_product_i (cpa_product_i),
      .out_valid_o   (out_valid_o),
      .out_ready_i   (out_ready_i),
      .word_o        (word_o),
      .idx_o         (idx_o),
      .last_o        (last_o),
`ifdef MRT_CARRY_RESOLVE_ZDETECT_EN
      .is_zero_o     (is_zero_o),
`endif
      .overflow_o    (overflow_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; sampling happens 2 time units after the rising edge
   task automatic tick();
      @(posedge clk_i);
      #2;
   endtask

   task automatic load(input logic [16:0] s3, input logic [16:0] s2,
                       input logic [16:0] s1, input logic [16:0] s0);
      cpa_product_i[3] = s3;
      cpa_product_i[2] = s2;
      cpa_product_i[1] = s1;
      cpa_product_i[0] = s0;
   endtask

   // Check the current beat against expectations, then advance one clock
   task automatic beat(input string tag, input logic [15:0] w, input int i,
                       input logic lst, input logic ovf);
      chk({tag, ".valid"}, 32'(out_valid_o), 32'd1);
      chk({tag, ".word"},  32'(word_o),      32'(w));
      chk({tag, ".idx"},   32'(idx_o),       32'(i));
      chk({tag, ".last"},  32'(last_o),      32'(lst));
      chk({tag, ".ovf"},   32'(overflow_o),  32'(ovf));
      tick();
   endtask

   // Offer a vector for one cycle while idle
   task automatic send(input logic [16:0] s3, input logic [16:0] s2,
                       input logic [16:0] s1, input logic [16:0] s0);
      load(s3, s2, s1, s0);
      in_valid_i = 1'b1;
      tick();
      in_valid_i = 1'b0;
   endtask

   initial begin
      rst_ni        = 1'b0;
      in_valid_i    = 1'b0;
      out_ready_i   = 1'b1;
      cpa_product_i = '0;
      tick();
      tick();

      // Reset state
      chk("rst.valid", 32'(out_valid_o), 32'd0);
      chk("rst.ready", 32'(in_ready_o),  32'd1);
      chk("rst.word",  32'(word_o),      32'd0);
      chk("rst.idx",   32'(idx_o),       32'd0);
      chk("rst.last",  32'(last_o),      32'd0);
      chk("rst.ovf",   32'(overflow_o),  32'd0);
      rst_ni = 1'b1;
      tick();
      chk("idle.valid", 32'(out_valid_o), 32'd0);

      // Ripple through upper segments
      send(17'h0FFFF, 17'h0FFFF, 17'h0FFFF, 17'h1FFFF);
      beat("rip0", 16'hFFFF, 0, 1'b0, 1'b0);
      beat("rip1", 16'h0000, 1, 1'b0, 1'b0);
      beat("rip2", 16'h0000, 2, 1'b0, 1'b0);
      beat("rip3", 16'h0000, 3, 1'b1, 1'b1);
      chk("rip.done.valid", 32'(out_valid_o), 32'd0);
      chk("rip.done.ready", 32'(in_ready_o),  32'd1);

      // All segments at maximum
      send(17'h1FFFF, 17'h1FFFF, 17'h1FFFF, 17'h1FFFF);
      beat("max0", 16'hFFFF, 0, 1'b0, 1'b0);
      beat("max1", 16'h0000, 1, 1'b0, 1'b0);
      beat("max2", 16'h0001, 2, 1'b0, 1'b0);
      beat("max3", 16'h0001, 3, 1'b1, 1'b1);
      chk("max.done.valid", 32'(out_valid_o), 32'd0);

      // Backpressure at idx 1 for three cycles
      send(17'h0FFFF, 17'h0FFFF, 17'h0FFFF, 17'h1FFFF);
      beat("bp0", 16'hFFFF, 0, 1'b0, 1'b0);
      out_ready_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk("bp.stall.valid", 32'(out_valid_o), 32'd1);
         chk("bp.stall.word",  32'(word_o),      32'h0000);
         chk("bp.stall.idx",   32'(idx_o),       32'd1);
         chk("bp.stall.ready", 32'(in_ready_o),  32'd0);
         tick();
      end
      out_ready_i = 1'b1;
      beat("bp1", 16'h0000, 1, 1'b0, 1'b0);
      beat("bp2", 16'h0000, 2, 1'b0, 1'b0);
      beat("bp3", 16'h0000, 3, 1'b1, 1'b1);
      chk("bp.done.valid", 32'(out_valid_o), 32'd0);

      // Back-to-back: B is held on the input while A streams and must not load early
      load(17'h00001, 17'h00001, 17'h00001, 17'h00001);
      in_valid_i = 1'b1;
      tick();
      load(17'h10000, 17'h10000, 17'h10000, 17'h10000);
      chk("b2b.busy.ready", 32'(in_ready_o), 32'd0);
      beat("b2bA0", 16'h0001, 0, 1'b0, 1'b0);
      beat("b2bA1", 16'h0001, 1, 1'b0, 1'b0);
      beat("b2bA2", 16'h0001, 2, 1'b0, 1'b0);
      chk("b2b.last.ready", 32'(in_ready_o), 32'd1);
      beat("b2bA3", 16'h0001, 3, 1'b1, 1'b0);
      in_valid_i = 1'b0;
      beat("b2bB0", 16'h0000, 0, 1'b0, 1'b0);
      beat("b2bB1", 16'h0001, 1, 1'b0, 1'b0);
      beat("b2bB2", 16'h0001, 2, 1'b0, 1'b0);
      beat("b2bB3", 16'h0001, 3, 1'b1, 1'b1);
      chk("b2b.done.valid", 32'(out_valid_o), 32'd0);

      // Reset mid-run at idx 2
      send(17'h0FFFF, 17'h0FFFF, 17'h0FFFF, 17'h1FFFF);
      beat("mr0", 16'hFFFF, 0, 1'b0, 1'b0);
      beat("mr1", 16'h0000, 1, 1'b0, 1'b0);
      chk("mr.pre.idx", 32'(idx_o), 32'd2);
      rst_ni = 1'b0;
      #1;
      chk("mr.rst.valid", 32'(out_valid_o), 32'd0);
      chk("mr.rst.ready", 32'(in_ready_o),  32'd1);
      chk("mr.rst.word",  32'(word_o),      32'd0);
      chk("mr.rst.idx",   32'(idx_o),       32'd0);
      chk("mr.rst.last",  32'(last_o),      32'd0);
      chk("mr.rst.ovf",   32'(overflow_o),  32'd0);
      tick();
      rst_ni = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("mr.post.valid", 32'(out_valid_o), 32'd0);
         chk("mr.post.ready", 32'(in_ready_o),  32'd1);
      end

`ifdef MRT_CARRY_RESOLVE_ZDETECT_EN
      // Zero detect: all-zero product
      send(17'h00000, 17'h00000, 17'h00000, 17'h00000);
      chk("z0.nonlast", 32'(is_zero_o), 32'd0);
      beat("z0_0", 16'h0000, 0, 1'b0, 1'b0);
      beat("z0_1", 16'h0000, 1, 1'b0, 1'b0);
      beat("z0_2", 16'h0000, 2, 1'b0, 1'b0);
      chk("z0.last.zero", 32'(is_zero_o), 32'd1);
      beat("z0_3", 16'h0000, 3, 1'b1, 1'b0);

      // Zero detect: a nonzero word earlier in the result
      send(17'h00000, 17'h00001, 17'h00000, 17'h00000);
      beat("z1_0", 16'h0000, 0, 1'b0, 1'b0);
      beat("z1_1", 16'h0000, 1, 1'b0, 1'b0);
      beat("z1_2", 16'h0001, 2, 1'b0, 1'b0);
      chk("z1.last.zero", 32'(is_zero_o), 32'd0);
      beat("z1_3", 16'h0000, 3, 1'b1, 1'b0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
